logic_unit_pipe: RTL and testbench



---
 rtl/logic_unit_pipe.sv | 145 ++++++++++++++
 tb/tb_logic_unit_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes, accumulate mode and transfer counter.
// Define LOGIC_UNIT_FLAGS_EN to build the registered zero/parity flags; otherwise both flags are tied to 0.
module logic_unit_pipe #(
   parameter int WIDTH       = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       a,
   input  logic [WIDTH-1:0]       b,
   input  logic [2:0]             op,
   input  logic                   acc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       result,
   output logic                   zero_flag,
   output logic                   parity_flag,
   output logic [COUNT_WIDTH-1:0] op_count
);

   typedef enum logic [2:0] {
      OP_OR    = 3'd0,
      OP_AND   = 3'd1,
      OP_XOR   = 3'd2,
      OP_NOT_A = 3'd3,
      OP_XNOR  = 3'd4,
      OP_NAND  = 3'd5,
      OP_NOR   = 3'd6,
      OP_PASS  = 3'd7
   } op_e;

   logic                   r_s1_valid;
   logic [WIDTH-1:0]       r_s1_a;
   logic [WIDTH-1:0]       r_s1_b;
   op_e                    r_s1_op;
   logic                   r_s1_acc;

   logic                   r_out_valid;
   logic [WIDTH-1:0]       r_result;
   logic [WIDTH-1:0]       r_last_result;
   logic [COUNT_WIDTH-1:0] r_op_count;

   logic                   w_s2_adv;
   logic                   w_in_ready;
   logic                   w_in_fire;
   logic                   w_s2_load;
   logic                   w_out_fire;
   logic [WIDTH-1:0]       w_b_eff;
   logic [WIDTH-1:0]       w_func;

   assign w_s2_adv   = !r_out_valid || out_ready;
   assign w_in_ready = !r_s1_valid || w_s2_adv;
   assign w_in_fire  = in_valid && w_in_ready && !reset;
   assign w_s2_load  = w_s2_adv && r_s1_valid;
   assign w_out_fire = r_out_valid && out_ready;

   // Accumulate reads last_result at S2 load time, so chained beats see their predecessor even across stalls.
   assign w_b_eff = r_s1_acc ? r_last_result : r_s1_b;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_func = r_s1_a;
      unique case (r_s1_op)
         OP_OR:    w_func = r_s1_a | w_b_eff;
         OP_AND:   w_func = r_s1_a & w_b_eff;
         OP_XOR:   w_func = r_s1_a ^ w_b_eff;
         OP_NOT_A: w_func = ~r_s1_a;
         OP_XNOR:  w_func = ~(r_s1_a ^ w_b_eff);
         OP_NAND:  w_func = ~(r_s1_a & w_b_eff);
         OP_NOR:   w_func = ~(r_s1_a | w_b_eff);
         OP_PASS:  w_func = r_s1_a;
         default:  w_func = r_s1_a;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
      end else if (w_in_ready) begin
         r_s1_valid <= in_valid;
      end
   end

   // NOTE: S1 payload is qualified by r_s1_valid, so it needs no reset.
   always_ff @(posedge clock) begin
      if (w_in_fire) begin
         r_s1_a   <= a;
         r_s1_b   <= b;
         r_s1_op  <= op_e'(op);
         r_s1_acc <= acc;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_out_valid   <= 1'b0;
         r_result      <= '0;
         r_last_result <= '0;
      end else if (w_s2_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_result      <= w_func;
            r_last_result <= w_func;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_op_count <= '0;
      end else if (w_out_fire) begin
         r_op_count <= r_op_count + COUNT_WIDTH'(1);
      end
   end

`ifdef LOGIC_UNIT_FLAGS_EN
   logic r_zero_flag;
   logic r_parity_flag;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_zero_flag   <= 1'b0;
         r_parity_flag <= 1'b0;
      end else if (w_s2_load) begin
         r_zero_flag   <= (w_func == '0);
         r_parity_flag <= ^w_func;
      end
   end

   assign zero_flag   = r_zero_flag;
   assign parity_flag = r_parity_flag;
`else
   assign zero_flag   = 1'b0;
   assign parity_flag = 1'b0;
`endif

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign op_count  = r_op_count;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe: ops, latency, accumulate chaining, backpressure, reset, flags, counter wrap.
module tb_logic_unit_pipe;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic        acc;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [2:0]  op;
   logic        in_ready;
   logic        out_valid;
   logic        zero_flag;
   logic        parity_flag;
   logic [7:0]  result;
   logic [15:0] op_count;

   logic        reset4;
   logic        in_ready4;
   logic        out_valid4;
   logic        zero_flag4;
   logic        parity_flag4;
   logic [7:0]  result4;
   logic [3:0]  op_count4;

   int checks = 0;
   int errors = 0;

   logic [7:0] q_res[$];
   logic       q_zf[$];
   logic       q_pf[$];

   logic [2:0] bop[32];
   logic [7:0] ba[32];
   logic [7:0] bb[32];
   logic       bacc[32];
   int         first_acc;
   int         first_out;

   logic [7:0] exp_res[8];
   logic       exp_zf[2];
   logic       exp_pf[2];

   logic_unit_pipe #(.WIDTH(8), .COUNT_WIDTH(16)) u_dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .acc(acc), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero_flag(zero_flag), .parity_flag(parity_flag), .op_count(op_count)
   );

   logic_unit_pipe #(.WIDTH(8), .COUNT_WIDTH(4)) u_dut4 (
      .clock(clock), .reset(reset4), .in_valid(in_valid), .in_ready(in_ready4),
      .a(a), .b(b), .op(op), .acc(acc), .out_valid(out_valid4), .out_ready(out_ready),
      .result(result4), .zero_flag(zero_flag4), .parity_flag(parity_flag4), .op_count(op_count4)
   );

   always #5 clock = ~clock;

   // Output transfers are recorded half a cycle before the edge that completes them.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         q_res.push_back(result);
         q_zf.push_back(zero_flag);
         q_pf.push_back(parity_flag);
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic set_beat(input int i, input logic [2:0] o, input logic [7:0] va,
                           input logic [7:0] vb, input logic vacc);
      bop[i]  = o;
      ba[i]   = va;
      bb[i]   = vb;
      bacc[i] = vacc;
   endtask

   task automatic run_beats(input string name, input int n, input bit toggle_rdy);
      int idx = 0;
      int cyc = 0;
      bit accept;
      first_acc = -1;
      first_out = -1;
      q_res.delete();
      q_zf.delete();
      q_pf.delete();
      while (q_res.size() < n && cyc < 400) begin
         out_ready = toggle_rdy ? ((cyc % 2) == 0) : 1'b1;
         if (idx < n) begin
            op = bop[idx]; a = ba[idx]; b = bb[idx]; acc = bacc[idx];
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clock);
         accept = in_valid && in_ready;
         if (accept && first_acc < 0) first_acc = cyc;
         if (out_valid && first_out < 0) first_out = cyc;
         @(posedge clock); #1;
         if (accept) idx++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (q_res.size() != n) begin
         errors++;
         $display("FAIL %s_drain: got %0d results, expected %0d", name, q_res.size(), n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; reset4 = 1'b1; out_ready = 1'b1; acc = 1'b0;
      in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'd0;
      repeat (2) @(posedge clock);
      #1;
      @(negedge clock);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h expected 00", result); end
      checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
      checks++; if (zero_flag !== 1'b0 || parity_flag !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got z=%b p=%b expected 0 0", zero_flag, parity_flag);
      end
      @(posedge clock); #1;
      reset = 1'b0; in_valid = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if (out_valid !== 1'b0 || op_count !== 16'd0) begin
         errors++; $display("FAIL reset_no_accept: got out_valid=%b op_count=%0d expected 0 0", out_valid, op_count);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_basic_ops();
      logic [2:0] ops[6];
      ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd2; ops[3] = 3'd4; ops[4] = 3'd5; ops[5] = 3'd6;
      exp_res[0] = 8'hFC; exp_res[1] = 8'h30; exp_res[2] = 8'hCC;
      exp_res[3] = 8'h33; exp_res[4] = 8'hCF; exp_res[5] = 8'h03;
      for (int i = 0; i < 6; i++) set_beat(i, ops[i], 8'hF0, 8'h3C, 1'b0);
      run_beats("basic", 6, 1'b0);
      checks++; if (first_out - first_acc != 2) begin
         errors++; $display("FAIL basic_latency: got %0d cycles expected 2", first_out - first_acc);
      end
      for (int i = 0; i < 6 && i < q_res.size(); i++) begin
         checks++; if (q_res[i] !== exp_res[i]) begin
            errors++; $display("FAIL basic_op%0d: got %h expected %h", ops[i], q_res[i], exp_res[i]);
         end
      end
      checks++; if (op_count !== 16'd6) begin errors++; $display("FAIL basic_op_count: got %0d expected 6", op_count); end
   endtask

   task automatic test_not_pass();
      set_beat(0, 3'd3, 8'hA5, 8'h00, 1'b0);
      set_beat(1, 3'd7, 8'hA5, 8'hFF, 1'b0);
      exp_res[0] = 8'h5A; exp_res[1] = 8'hA5;
      run_beats("not_pass", 2, 1'b0);
      for (int i = 0; i < 2 && i < q_res.size(); i++) begin
         checks++; if (q_res[i] !== exp_res[i]) begin
            errors++; $display("FAIL not_pass_%0d: got %h expected %h", i, q_res[i], exp_res[i]);
         end
      end
   endtask

   task automatic test_acc_chain();
      set_beat(0, 3'd7, 8'h01, 8'h00, 1'b0);
      set_beat(1, 3'd2, 8'h02, 8'hAA, 1'b1);
      set_beat(2, 3'd2, 8'h04, 8'hAA, 1'b1);
      set_beat(3, 3'd2, 8'h08, 8'hAA, 1'b1);
      exp_res[0] = 8'h01; exp_res[1] = 8'h03; exp_res[2] = 8'h07; exp_res[3] = 8'h0F;
      for (int pass = 0; pass < 2; pass++) begin
         run_beats(pass == 0 ? "acc_chain" : "acc_chain_toggle", 4, pass == 1);
         for (int i = 0; i < 4 && i < q_res.size(); i++) begin
            checks++; if (q_res[i] !== exp_res[i]) begin
               errors++; $display("FAIL acc_chain_p%0d_%0d: got %h expected %h", pass, i, q_res[i], exp_res[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int idx = 0;
      int cyc = 0;
      bit accept;
      set_beat(0, 3'd0, 8'h01, 8'h02, 1'b0);
      set_beat(1, 3'd0, 8'h04, 8'h08, 1'b0);
      set_beat(2, 3'd0, 8'h10, 8'h20, 1'b0);
      exp_res[0] = 8'h03; exp_res[1] = 8'h0C; exp_res[2] = 8'h30;
      q_res.delete(); q_zf.delete(); q_pf.delete();
      out_ready = 1'b0;
      while (cyc < 30 && q_res.size() < 3) begin
         if (cyc == 5) out_ready = 1'b1;
         if (idx < 3) begin
            op = bop[idx]; a = ba[idx]; b = bb[idx]; acc = bacc[idx]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clock);
         accept = in_valid && in_ready;
         if (cyc >= 2 && cyc < 5) begin
            checks++; if (out_valid !== 1'b1 || result !== 8'h03) begin
               errors++; $display("FAIL bp_hold_c%0d: got v=%b r=%h expected v=1 r=03", cyc, out_valid, result);
            end
         end
         if (cyc == 4) begin
            checks++; if (idx != 2) begin errors++; $display("FAIL bp_accepted: got %0d beats expected 2", idx); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
         end
         @(posedge clock); #1;
         if (accept) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      checks++; if (q_res.size() != 3) begin errors++; $display("FAIL bp_drain: got %0d results expected 3", q_res.size()); end
      for (int i = 0; i < 3 && i < q_res.size(); i++) begin
         checks++; if (q_res[i] !== exp_res[i]) begin
            errors++; $display("FAIL bp_order_%0d: got %h expected %h", i, q_res[i], exp_res[i]);
         end
      end
   endtask

   task automatic test_reset_inflight();
      out_ready = 1'b0;
      op = 3'd0; a = 8'hC0; b = 8'h00; acc = 1'b0; in_valid = 1'b1;
      @(posedge clock); #1;
      a = 8'h03;
      @(posedge clock); #1;
      in_valid = 1'b0; reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      checks++; if (out_valid !== 1'b0 || op_count !== 16'd0 || result !== 8'h00) begin
         errors++; $display("FAIL rst_inflight_state: got v=%b cnt=%0d r=%h expected 0 0 00", out_valid, op_count, result);
      end
      @(posedge clock); #1;
      set_beat(0, 3'd0, 8'h11, 8'hFF, 1'b1);
      run_beats("rst_inflight", 1, 1'b0);
      checks++; if (q_res.size() > 0 && q_res[0] !== 8'h11) begin
         errors++; $display("FAIL rst_inflight_acc: got %h expected 11", q_res[0]);
      end
      checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL rst_inflight_count: got %0d expected 1", op_count); end
   endtask

   task automatic test_flags();
      set_beat(0, 3'd1, 8'h0F, 8'hF0, 1'b0);
      set_beat(1, 3'd0, 8'h07, 8'h00, 1'b0);
      exp_res[0] = 8'h00; exp_res[1] = 8'h07;
`ifdef LOGIC_UNIT_FLAGS_EN
      exp_zf[0] = 1'b1; exp_pf[0] = 1'b0;
      exp_zf[1] = 1'b0; exp_pf[1] = 1'b1;
`else
      exp_zf[0] = 1'b0; exp_pf[0] = 1'b0;
      exp_zf[1] = 1'b0; exp_pf[1] = 1'b0;
`endif
      run_beats("flags", 2, 1'b0);
      for (int i = 0; i < 2 && i < q_res.size(); i++) begin
         checks++; if (q_res[i] !== exp_res[i] || q_zf[i] !== exp_zf[i] || q_pf[i] !== exp_pf[i]) begin
            errors++; $display("FAIL flags_%0d: got r=%h z=%b p=%b expected r=%h z=%b p=%b",
                               i, q_res[i], q_zf[i], q_pf[i], exp_res[i], exp_zf[i], exp_pf[i]);
         end
      end
   endtask

   task automatic test_count_wrap();
      logic [15:0] cnt0;
      cnt0 = op_count;
      reset4 = 1'b0;
      for (int i = 0; i < 17; i++) set_beat(i, 3'd7, 8'(i), 8'h00, 1'b0);
      run_beats("wrap", 17, 1'b0);
      checks++; if (op_count4 !== 4'd1) begin errors++; $display("FAIL wrap_count4: got %0d expected 1", op_count4); end
      checks++; if (op_count !== cnt0 + 16'd17) begin
         errors++; $display("FAIL wrap_count16: got %0d expected %0d", op_count, cnt0 + 16'd17);
      end
   endtask

   initial begin
      test_reset();
      test_basic_ops();
      test_not_pass();
      test_acc_chain();
      test_backpressure();
      test_reset_inflight();
      test_flags();
      test_count_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
